modbus_poll_scheduler: RTL and testbench

//  Modbus RTU master sequencer in front of the modbus UART frame block. Holds NUM_SLOTS request frames,

---
 rtl/modbus_pkg.sv | 31 +++
 rtl/modbus_slot_table.sv | 70 +++++++
 rtl/modbus_poll_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_modbus_poll_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU poll scheduler.
//   state_e        : sequencer states
//   *_LSB          : bit offsets of the fields in the modbus txdata/rxdata words
//   next_frame_id  : frame id increment that skips 0
package modbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GAP       = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_TX   = 3'd3,
    ST_WAIT_RESP = 3'd4
  } state_e;

  // txdata word: id[7:0], len[15:8], frame bytes from bit 16 up
  localparam int ID_LSB         = 0;
  localparam int LEN_LSB        = 8;
  localparam int TX_PAYLOAD_LSB = 16;

  // rxdata word: ack[7:0], rx_id[15:8], rxlen[23:16], payload from bit 24 up
  localparam int RXID_LSB    = 8;
  localparam int RXLEN_LSB   = 16;
  localparam int PAYLOAD_LSB = 24;

  // The modbus block starts a frame whenever the id changes, so id 0 is
  // reserved as "nothing sent yet" and the counter wraps 255 -> 1.
  function automatic logic [7:0] next_frame_id(input logic [7:0] id);
    return (id == 8'd255) ? 8'd1 : id + 8'd1;
  endfunction

endpackage

// File: rtl/modbus_slot_table.sv
// Request slot storage for the poll scheduler.
//   clk, rst_n          : clock, async active-low reset (clears enables only)
//   cfg_we_i..frame_i   : single-cycle slot write port
//   rr_i                : round-robin start pointer
//   any_en_o            : at least one slot enabled
//   nxt_slot_o          : first enabled slot at or after rr_i (wrapping)
//   rd_slot_i           : slot read index
//   rd_len_o/rd_frame_o : length and frame bytes of rd_slot_i
module modbus_slot_table
  import modbus_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int FRAME_W   = 48,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we_i,
  input  logic [SLOT_W-1:0]  cfg_slot_i,
  input  logic               cfg_en_i,
  input  logic [7:0]         cfg_len_i,
  input  logic [FRAME_W-1:0] cfg_frame_i,
  input  logic [SLOT_W-1:0]  rr_i,
  output logic               any_en_o,
  output logic [SLOT_W-1:0]  nxt_slot_o,
  input  logic [SLOT_W-1:0]  rd_slot_i,
  output logic [7:0]         rd_len_o,
  output logic [FRAME_W-1:0] rd_frame_o
);

  logic [NUM_SLOTS-1:0] en_q;
  logic [7:0]           len_q   [NUM_SLOTS];
  logic [FRAME_W-1:0]   frame_q [NUM_SLOTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
    end else if (cfg_we_i) begin
      en_q[cfg_slot_i] <= cfg_en_i;
    end
  end

  // Frame contents are only meaningful once the slot is enabled.
  always_ff @(posedge clk) begin
    if (cfg_we_i) begin
      len_q[cfg_slot_i]   <= cfg_len_i;
      frame_q[cfg_slot_i] <= cfg_frame_i;
    end
  end

  // Scan offsets from high to low so the smallest offset from rr_i wins.
  // NUM_SLOTS is a power of two, so the index wraps by truncation.
  always_comb begin
    logic [SLOT_W-1:0] idx;
    idx        = rr_i;
    any_en_o   = 1'b0;
    nxt_slot_o = rr_i;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      idx = rr_i + SLOT_W'(i);
      if (en_q[idx]) begin
        any_en_o   = 1'b1;
        nxt_slot_o = idx;
      end
    end
  end

  assign rd_len_o   = len_q[rd_slot_i];
  assign rd_frame_o = frame_q[rd_slot_i];

endmodule

// File: rtl/modbus_poll_scheduler.sv
// Modbus RTU master sequencer in front of the modbus UART frame block.
// Issues enabled request slots round-robin, enforces the inter-frame gap,
// waits for each reply with timeout and bounded retries, reports per slot.
//   clk, rst_n          : clock, async active-low reset
//   enable              : run; dropping it parks the sequencer once back in IDLE
//   cfg_we/slot/en/len/frame : slot configuration write port
//   mb_txdata           : {frame, len, id} to the modbus block
//   mb_tx_enable        : modbus transmitter busy
//   mb_rxdata           : {payload, rxlen, rx_id, ack} from the modbus block
//   resp_valid          : 1-cycle strobe, reply captured in resp_slot/len/data
//   err_valid           : 1-cycle strobe, resp_slot exhausted its retries
//   busy                : sequencer not in IDLE
module modbus_poll_scheduler
  import modbus_pkg::*;
#(
  parameter int ClkFrequency  = 12000000,
  parameter int Baud          = 9600,
  parameter int TX_BUFFERSIZE = 64,
  parameter int RX_BUFFERSIZE = 64,
  parameter int NUM_SLOTS     = 4,
  parameter int TIMEOUT_MS    = 100,
  parameter int RETRIES       = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot,
  input  logic                         cfg_en,
  input  logic [7:0]                   cfg_len,
  input  logic [TX_BUFFERSIZE-17:0]    cfg_frame,
  output logic [TX_BUFFERSIZE-1:0]     mb_txdata,
  input  logic                         mb_tx_enable,
  input  logic [RX_BUFFERSIZE-1:0]     mb_rxdata,
  output logic                         resp_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] resp_slot,
  output logic [7:0]                   resp_len,
  output logic [RX_BUFFERSIZE-25:0]    resp_data,
  output logic                         err_valid,
  output logic                         busy
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int FW = TX_BUFFERSIZE - 16;
  localparam int DW = RX_BUFFERSIZE - 24;

  // 3.5 characters of 11 bits is ~40 bit times of line silence.
  localparam logic [31:0] GAP_CYC   = 32'(ClkFrequency * 40 / Baud);
  localparam logic [31:0] TO_CYC    = 32'((ClkFrequency / 1000) * TIMEOUT_MS);
  localparam logic [7:0]  RETRIES_L = 8'(RETRIES);

  state_e          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [7:0]      attempt_q, attempt_d;
  logic [7:0]      id_q, id_d;
  logic [7:0]      rx_ref_q, rx_ref_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [SW-1:0]   rr_q, rr_d;
  logic            tx_seen_q, tx_seen_d;
  logic [TX_BUFFERSIZE-1:0] txdata_q, txdata_d;
  logic            resp_valid_q, resp_valid_d;
  logic            err_valid_q, err_valid_d;
  logic [SW-1:0]   resp_slot_q, resp_slot_d;
  logic [7:0]      resp_len_q, resp_len_d;
  logic [DW-1:0]   resp_data_q, resp_data_d;

  logic            any_en;
  logic [SW-1:0]   nxt_slot;
  logic [7:0]      rd_len;
  logic [FW-1:0]   rd_frame;

  logic [7:0]      rx_id, rx_len;
  logic            rx_new, reply, timeout, retry, start;
  logic            ack_unused;

  modbus_slot_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .FRAME_W   (FW),
    .SLOT_W    (SW)
  ) u_slots (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_slot_i  (cfg_slot),
    .cfg_en_i    (cfg_en),
    .cfg_len_i   (cfg_len),
    .cfg_frame_i (cfg_frame),
    .rr_i        (rr_q),
    .any_en_o    (any_en),
    .nxt_slot_o  (nxt_slot),
    .rd_slot_i   (slot_q),
    .rd_len_o    (rd_len),
    .rd_frame_o  (rd_frame)
  );

  assign rx_id      = mb_rxdata[RXID_LSB +: 8];
  assign rx_len     = mb_rxdata[RXLEN_LSB +: 8];
  assign ack_unused = ^mb_rxdata[7:0];

  assign start  = enable && any_en;
  // A changed rx_id means the modbus block finished receiving something.
  assign rx_new = (rx_id != rx_ref_q);
  assign reply  = (state_q == ST_WAIT_RESP) && rx_new && (rx_len != 8'd0);
  // Reply has priority over a coincident timer expiry; a late transmitter
  // rise on the last cycle also wins over the timeout.
  assign timeout = ((state_q == ST_WAIT_TX) && !tx_seen_q && !mb_tx_enable &&
                    (cnt_q == TO_CYC - 32'd1)) ||
                   ((state_q == ST_WAIT_RESP) && !reply &&
                    (cnt_q == TO_CYC - 32'd1));
  assign retry   = timeout && (attempt_q < RETRIES_L);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start) state_d = ST_GAP;
      ST_GAP:       if (cnt_q >= GAP_CYC - 32'd1) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (timeout)                        state_d = retry ? ST_GAP : ST_IDLE;
        else if (tx_seen_q && !mb_tx_enable) state_d = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (reply)        state_d = ST_IDLE;
        else if (timeout) state_d = retry ? ST_GAP : ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    busy         = (state_q != ST_IDLE);
    cnt_d        = cnt_q;
    attempt_d    = attempt_q;
    id_d         = id_q;
    rx_ref_d     = rx_ref_q;
    slot_d       = slot_q;
    rr_d         = rr_q;
    tx_seen_d    = tx_seen_q;
    txdata_d     = txdata_q;
    resp_valid_d = 1'b0;
    err_valid_d  = 1'b0;
    resp_slot_d  = resp_slot_q;
    resp_len_d   = resp_len_q;
    resp_data_d  = resp_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          slot_d    = nxt_slot;
          attempt_d = 8'd0;
          cnt_d     = 32'd0;
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 32'd1;
      end
      ST_ISSUE: begin
        id_d      = next_frame_id(id_q);
        // Slot contents are read here, so a config write lands on the next issue.
        txdata_d  = {rd_frame, rd_len, next_frame_id(id_q)};
        rx_ref_d  = rx_id;
        cnt_d     = 32'd0;
        tx_seen_d = 1'b0;
      end
      ST_WAIT_TX: begin
        if (!tx_seen_q) begin
          tx_seen_d = mb_tx_enable;
          cnt_d     = cnt_q + 32'd1;
        end else if (!mb_tx_enable) begin
          cnt_d = 32'd0;
        end
      end
      ST_WAIT_RESP: begin
        cnt_d = cnt_q + 32'd1;
        // Zero-length receptions (runts, our own echo) only move the reference.
        if (rx_new && (rx_len == 8'd0)) rx_ref_d = rx_id;
        if (reply) begin
          resp_valid_d = 1'b1;
          resp_slot_d  = slot_q;
          resp_len_d   = rx_len;
          resp_data_d  = mb_rxdata[RX_BUFFERSIZE-1:PAYLOAD_LSB];
          rr_d         = slot_q + SW'(1);
        end
      end
      default: ;
    endcase

    if (timeout) begin
      cnt_d = 32'd0;
      if (retry) begin
        attempt_d = attempt_q + 8'd1;
      end else begin
        err_valid_d = 1'b1;
        resp_slot_d = slot_q;
        rr_d        = slot_q + SW'(1);
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      attempt_q    <= '0;
      id_q         <= '0;
      rx_ref_q     <= '0;
      slot_q       <= '0;
      rr_q         <= '0;
      tx_seen_q    <= 1'b0;
      txdata_q     <= '0;
      resp_valid_q <= 1'b0;
      err_valid_q  <= 1'b0;
      resp_slot_q  <= '0;
      resp_len_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      attempt_q    <= attempt_d;
      id_q         <= id_d;
      rx_ref_q     <= rx_ref_d;
      slot_q       <= slot_d;
      rr_q         <= rr_d;
      tx_seen_q    <= tx_seen_d;
      txdata_q     <= txdata_d;
      resp_valid_q <= resp_valid_d;
      err_valid_q  <= err_valid_d;
      resp_slot_q  <= resp_slot_d;
      resp_len_q   <= resp_len_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign mb_txdata  = txdata_q;
  assign resp_valid = resp_valid_q;
  assign err_valid  = err_valid_q;
  assign resp_slot  = resp_slot_q;
  assign resp_len   = resp_len_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_modbus_poll_scheduler.sv
module tb_modbus_poll_scheduler;

  // 230400 Hz clock, 115200 baud, 1 ms timeout:
  // gap = 230400*40/115200 = 80 cycles, timeout = 230*1 = 230 cycles.
  localparam int GAP     = 80;
  localparam int TO      = 230;
  localparam int TX_TIME = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_slot = '0;
  logic        cfg_en = 1'b0;
  logic [7:0]  cfg_len = '0;
  logic [47:0] cfg_frame = '0;
  logic [63:0] mb_txdata;
  logic        mb_tx_enable = 1'b0;
  logic [63:0] mb_rxdata = '0;
  logic        resp_valid;
  logic [1:0]  resp_slot;
  logic [7:0]  resp_len;
  logic [39:0] resp_data;
  logic        err_valid;
  logic        busy;

  modbus_poll_scheduler #(
    .ClkFrequency (230400),
    .Baud         (115200),
    .TX_BUFFERSIZE(64),
    .RX_BUFFERSIZE(64),
    .NUM_SLOTS    (4),
    .TIMEOUT_MS   (1),
    .RETRIES      (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cfg_we       (cfg_we),
    .cfg_slot     (cfg_slot),
    .cfg_en       (cfg_en),
    .cfg_len      (cfg_len),
    .cfg_frame    (cfg_frame),
    .mb_txdata    (mb_txdata),
    .mb_tx_enable (mb_tx_enable),
    .mb_rxdata    (mb_rxdata),
    .resp_valid   (resp_valid),
    .resp_slot    (resp_slot),
    .resp_len     (resp_len),
    .resp_data    (resp_data),
    .err_valid    (err_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Modbus block + slave model: a new nonzero id starts a TX_TIME-cycle
  // transmission; unless silent, the slave reply appears reply_dly ticks
  // after the transmitter goes idle.
  longint      tick = 0;
  logic [7:0]  last_id = '0;
  logic [7:0]  rx_ctr = '0;
  int          tx_left = 0;
  int          rcnt = 0;
  bit          silent = 1'b0;
  int          reply_dly = 20;
  logic [7:0]  reply_len = 8'd5;
  logic [7:0]  iss_id[$];
  logic [7:0]  iss_len[$];
  logic [47:0] iss_frame[$];
  longint      iss_tick[$];
  longint      last_quiet = 0;
  longint      min_gap = 1000000;
  int          zero_seen = 0;
  bit          nz_armed = 1'b0;
  int          resp_cnt = 0;
  int          err_cnt = 0;

  always begin
    @(posedge clk);
    #1;
    tick++;
    if (!rst_n) nz_armed = 1'b0;
    if (rst_n && nz_armed && mb_txdata[7:0] == 8'd0) zero_seen++;
    if (mb_txdata[7:0] != last_id) begin
      last_id = mb_txdata[7:0];
      if (last_id != 8'd0) begin
        iss_id.push_back(last_id);
        iss_len.push_back(mb_txdata[15:8]);
        iss_frame.push_back(mb_txdata[63:16]);
        iss_tick.push_back(tick);
        if (tick - last_quiet < min_gap) min_gap = tick - last_quiet;
        mb_tx_enable = 1'b1;
        tx_left = TX_TIME;
        nz_armed = 1'b1;
      end
    end else if (tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) begin
        mb_tx_enable = 1'b0;
        last_quiet = tick;
        if (!silent) rcnt = reply_dly;
      end
    end else if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        rx_ctr++;
        mb_rxdata = {32'hC0DE0000, rx_ctr, reply_len, rx_ctr, 8'h00};
        last_quiet = tick;
      end
    end
  end

  always @(negedge clk) begin
    if (resp_valid) resp_cnt++;
    if (err_valid) err_cnt++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic cfg_write(input logic [1:0] s, input logic en, input logic [7:0] len,
                           input logic [47:0] frame);
    cfg_we = 1'b1; cfg_slot = s; cfg_en = en; cfg_len = len; cfg_frame = frame;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic clear_log();
    iss_id.delete(); iss_len.delete(); iss_frame.delete(); iss_tick.delete();
    min_gap = 1000000;
    last_quiet = tick;
  endtask

  task automatic wait_resps(input int n, input int limit, output bit ok);
    int seen = 0;
    int c = 0;
    while (seen < n && c < limit) begin
      step();
      c++;
      if (resp_valid === 1'b1) seen++;
    end
    ok = (seen == n);
  endtask

  // which: 1 = resp_valid, 2 = err_valid, 0 = bound expired
  task automatic wait_done(input int limit, output int which);
    int c = 0;
    which = 0;
    while (which == 0 && c < limit) begin
      step();
      c++;
      if (resp_valid === 1'b1) which = 1;
      else if (err_valid === 1'b1) which = 2;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step();
    checks++; if (mb_txdata !== 64'd0) begin failures++; $display("FAIL rst_txdata got=%0h exp=0", mb_txdata); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL rst_err_valid got=%b exp=0", err_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if ({resp_slot, resp_len, resp_data} !== 50'd0) begin failures++; $display("FAIL rst_resp_fields got=%0h exp=0", {resp_slot, resp_len, resp_data}); end
    clear_log();
    enable = 1'b1;
    step(60);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_noslot_busy got=%b exp=0", busy); end
    checks++; if (iss_id.size() != 0) begin failures++; $display("FAIL rst_noslot_issues got=%0d exp=0", iss_id.size()); end
    enable = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    silent = 1'b0; reply_dly = 20; reply_len = 8'd5;
    cfg_write(2'd0, 1'b1, 8'd6, 48'h010000000301);
    clear_log();
    enable = 1'b1;
    wait_resps(1, 2000, ok);
    enable = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL single_resp got=none exp=resp_valid"); end
    checks++; if (resp_slot !== 2'd0) begin failures++; $display("FAIL single_slot got=%0d exp=0", resp_slot); end
    checks++; if (resp_len !== 8'd5) begin failures++; $display("FAIL single_len got=%0d exp=5", resp_len); end
    checks++; if (resp_data !== 40'hC0DE000001) begin failures++; $display("FAIL single_data got=%0h exp=c0de000001", resp_data); end
    checks++; if (iss_id.size() != 1) begin failures++; $display("FAIL single_issues got=%0d exp=1", iss_id.size()); end
    else begin
      checks++; if (iss_id[0] !== 8'd1) begin failures++; $display("FAIL single_id got=%0d exp=1", iss_id[0]); end
      checks++; if (iss_len[0] !== 8'd6) begin failures++; $display("FAIL single_txlen got=%0d exp=6", iss_len[0]); end
      checks++; if (iss_frame[0] !== 48'h010000000301) begin failures++; $display("FAIL single_frame got=%0h exp=010000000301", iss_frame[0]); end
    end
    step(200);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    checks++; if (resp_cnt != 1 || err_cnt != 0) begin failures++; $display("FAIL single_strobes got=%0d/%0d exp=1/0", resp_cnt, err_cnt); end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    int r0 = resp_cnt;
    int e0 = err_cnt;
    silent = 1'b1;
    clear_log();
    enable = 1'b1;
    while (!(iss_id.size() > 0 && tx_left == 0) && c < 2000) begin step(); c++; end
    step(20);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_pre_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || mb_txdata !== 64'd0) begin failures++; $display("FAIL rmid_async got=busy%b/tx%0h exp=0/0", busy, mb_txdata); end
    step();
    checks++; if ({resp_valid, err_valid, busy} !== 3'b000) begin failures++; $display("FAIL rmid_outputs got=%b exp=000", {resp_valid, err_valid, busy}); end
    step();
    rst_n = 1'b1;
    step(300);
    checks++; if (iss_id.size() != 1 || busy !== 1'b0) begin failures++; $display("FAIL rmid_slots_cleared got=%0d/%b exp=1/0", iss_id.size(), busy); end
    checks++; if (resp_cnt != r0 || err_cnt != e0) begin failures++; $display("FAIL rmid_no_strobe got=%0d/%0d exp=%0d/%0d", resp_cnt, err_cnt, r0, e0); end
    enable = 1'b0;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [7:0] exp_addr [4] = '{8'h01, 8'h03, 8'h01, 8'h03};
    silent = 1'b0; reply_dly = 20;
    cfg_write(2'd0, 1'b1, 8'd6, 48'h010000000301);
    cfg_write(2'd1, 1'b0, 8'd6, 48'h010000000302);
    cfg_write(2'd2, 1'b1, 8'd6, 48'h0A0000000303);
    cfg_write(2'd3, 1'b0, 8'd6, 48'h010000000304);
    clear_log();
    enable = 1'b1;
    wait_resps(4, 5000, ok);
    enable = 1'b0;
    step(10);
    checks++; if (!ok) begin failures++; $display("FAIL rr_resps got=short exp=4"); end
    checks++; if (iss_id.size() != 4) begin failures++; $display("FAIL rr_issues got=%0d exp=4", iss_id.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (iss_frame[i][7:0] !== exp_addr[i]) begin
          failures++; $display("FAIL rr_order[%0d] got=%0h exp=%0h", i, iss_frame[i][7:0], exp_addr[i]);
        end
      end
      checks++; if (iss_id[0] !== 8'd1 || iss_id[3] !== 8'd4) begin failures++; $display("FAIL rr_ids got=%0d..%0d exp=1..4", iss_id[0], iss_id[3]); end
    end
    checks++; if (min_gap < GAP) begin failures++; $display("FAIL rr_gap got=%0d exp>=%0d", min_gap, GAP); end
    checks++; if (resp_slot !== 2'd2) begin failures++; $display("FAIL rr_last_slot got=%0d exp=2", resp_slot); end
  endtask

  task automatic test_retry();
    int which;
    int r0 = resp_cnt;
    int e0 = err_cnt;
    cfg_write(2'd2, 1'b0, 8'd6, 48'h0A0000000303);
    silent = 1'b1;
    clear_log();
    enable = 1'b1;
    wait_done(3000, which);
    enable = 1'b0;
    step(400);
    checks++; if (which != 2) begin failures++; $display("FAIL retry_outcome got=%0d exp=2", which); end
    checks++; if (resp_slot !== 2'd0) begin failures++; $display("FAIL retry_slot got=%0d exp=0", resp_slot); end
    checks++; if (iss_id.size() != 3) begin failures++; $display("FAIL retry_issues got=%0d exp=3", iss_id.size()); end
    else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (iss_tick[i] - iss_tick[i-1] < TO + GAP || iss_tick[i] - iss_tick[i-1] > TO + GAP + TX_TIME + 10) begin
          failures++; $display("FAIL retry_spacing[%0d] got=%0d exp=%0d..%0d", i, iss_tick[i] - iss_tick[i-1], TO + GAP, TO + GAP + TX_TIME + 10);
        end
      end
      checks++; if (iss_frame[2][7:0] !== 8'h01) begin failures++; $display("FAIL retry_same_slot got=%0h exp=01", iss_frame[2][7:0]); end
    end
    checks++; if (err_cnt - e0 != 1 || resp_cnt != r0) begin failures++; $display("FAIL retry_strobes got=err%0d/resp%0d exp=1/0", err_cnt - e0, resp_cnt - r0); end
  endtask

  task automatic test_timeout_edge();
    int which;
    int r0 = resp_cnt;
    int e0 = err_cnt;
    silent = 1'b0; reply_dly = TO;
    clear_log();
    enable = 1'b1;
    wait_done(2000, which);
    enable = 1'b0;
    step(400);
    checks++; if (which != 1) begin failures++; $display("FAIL edge_reply_wins got=%0d exp=1", which); end
    checks++; if (iss_id.size() != 1) begin failures++; $display("FAIL edge_no_retry got=%0d exp=1", iss_id.size()); end
    checks++; if (resp_cnt - r0 != 1 || err_cnt != e0) begin failures++; $display("FAIL edge_strobes got=resp%0d/err%0d exp=1/0", resp_cnt - r0, err_cnt - e0); end
    reply_dly = TO + 1;
    r0 = resp_cnt; e0 = err_cnt;
    clear_log();
    enable = 1'b1;
    wait_done(3000, which);
    enable = 1'b0;
    step(400);
    checks++; if (which != 2) begin failures++; $display("FAIL late_outcome got=%0d exp=2", which); end
    checks++; if (iss_id.size() != 3) begin failures++; $display("FAIL late_issues got=%0d exp=3", iss_id.size()); end
    checks++; if (resp_cnt != r0 || err_cnt - e0 != 1) begin failures++; $display("FAIL late_strobes got=resp%0d/err%0d exp=0/1", resp_cnt - r0, err_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad = 0;
    int wraps = 0;
    int zeros = 0;
    int r0 = resp_cnt;
    silent = 1'b0; reply_dly = 20;
    zero_seen = 0;
    clear_log();
    enable = 1'b1;
    wait_resps(300, 60000, ok);
    enable = 1'b0;
    step(200);
    checks++; if (!ok || resp_cnt - r0 != 300) begin failures++; $display("FAIL b2b_resps got=%0d exp=300", resp_cnt - r0); end
    checks++; if (iss_id.size() != 300) begin failures++; $display("FAIL b2b_issues got=%0d exp=300", iss_id.size()); end
    else begin
      for (int i = 0; i < 300; i++) begin
        if (iss_id[i] == 8'd0) zeros++;
        if (i > 0) begin
          if (iss_id[i] != ((iss_id[i-1] == 8'd255) ? 8'd1 : iss_id[i-1] + 8'd1)) bad++;
          if (iss_id[i-1] == 8'd255 && iss_id[i] == 8'd1) wraps++;
        end
      end
      checks++; if (iss_id[0] !== 8'd12 || iss_id[299] !== 8'd56) begin failures++; $display("FAIL b2b_endpoints got=%0d..%0d exp=12..56", iss_id[0], iss_id[299]); end
      checks++; if (iss_id[244] !== 8'd1) begin failures++; $display("FAIL b2b_wrap_pos got=%0d exp=1", iss_id[244]); end
      checks++; if (bad != 0) begin failures++; $display("FAIL b2b_sequence got=%0d_breaks exp=0", bad); end
      checks++; if (wraps != 1) begin failures++; $display("FAIL b2b_wraps got=%0d exp=1", wraps); end
      checks++; if (zeros != 0) begin failures++; $display("FAIL b2b_zero_id got=%0d exp=0", zeros); end
    end
    checks++; if (zero_seen != 0) begin failures++; $display("FAIL b2b_zero_driven got=%0d exp=0", zero_seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_round_robin();
    test_retry();
    test_timeout_edge();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
